// File: rtl/sprite_bitmap_writer_pkg.sv
// Shared definitions for the sprite bitmap path.
//   PAL_WHITE / PAL_BLACK : the two palette colours (index 0 / index 1)
//   SPRITE_ADDR_W         : default sprite frame RAM address width
//   state_t               : load sequencer states
//   is_off_palette()      : pixel is neither pure white nor pure black
//   quantize()            : RGB pixel -> 1-bit palette index
package sprite_pkg;

  localparam int          SPRITE_ADDR_W = 10;
  localparam logic [23:0] PAL_WHITE     = 24'hFFFFFF;
  localparam logic [23:0] PAL_BLACK     = 24'h000000;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } state_t;

  function automatic logic is_off_palette(input logic [23:0] px);
    return (px != PAL_WHITE) && (px != PAL_BLACK);
  endfunction

  // Exact palette colours map directly; anything else is thresholded on
  // R+G+B. The 10-bit sum cannot overflow (max 765).
  function automatic logic quantize(input logic [23:0] px, input logic [9:0] thresh);
    logic [9:0] sum;
    sum = 10'(px[23:16]) + 10'(px[15:8]) + 10'(px[7:0]);
    if (px == PAL_WHITE) return 1'b0;
    if (px == PAL_BLACK) return 1'b1;
    return (sum < thresh);
  endfunction

endpackage

// File: rtl/sprite_bitmap_writer.sv
// Streams 24-bit RGB pixels into a 1-bit-per-pixel sprite frame RAM.
// Ports:
//   Clk, Reset_n          : clock, asynchronous active-low reset
//   start, abort          : begin a load (IDLE only) / cancel a load (LOAD only)
//   base_addr             : first RAM address, latched on an accepted start
//   pixel_in/valid/ready  : pixel stream handshake, {R,G,B}
//   wr_en/wr_addr/wr_data : registered RAM write port, one cycle after accept
//   busy, done            : load in progress / one-cycle completion pulse
//   off_palette_cnt       : pixels in this load that were not pure white/black
module sprite_bitmap_writer
  import sprite_pkg::*;
#(
  parameter int         ADDR_W  = SPRITE_ADDR_W,
  parameter int         NUM_PIX = 1024,
  parameter logic [9:0] THRESH  = 10'd384
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [23:0]       pixel_in,
  input  logic              pixel_valid,
  output logic              pixel_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   off_palette_cnt
);

  localparam int               CNT_W    = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_PIX - 1);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  pix_cnt;
  logic [ADDR_W-1:0] base_q;
  logic              start_ok;
  logic              accept;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // abort outranks a same-cycle accept, so the pixel on the bus is dropped.
  always_comb begin
    state_nxt   = state;
    start_ok    = 1'b0;
    accept      = 1'b0;
    pixel_ready = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (state)
      IDLE: begin
        start_ok = start;
        if (start) state_nxt = LOAD;
      end
      LOAD: begin
        pixel_ready = 1'b1;
        busy        = 1'b1;
        accept      = pixel_valid && !abort;
        if (abort)                           state_nxt = IDLE;
        else if (accept && pix_cnt == LAST_IDX) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      base_q          <= '0;
      pix_cnt         <= '0;
      off_palette_cnt <= '0;
      wr_en           <= 1'b0;
      wr_addr         <= '0;
      wr_data         <= 1'b0;
    end else begin
      wr_en <= accept;
      if (start_ok) begin
        base_q          <= base_addr;
        pix_cnt         <= '0;
        off_palette_cnt <= '0;
      end
      if (accept) begin
        pix_cnt         <= pix_cnt + 1'b1;
        off_palette_cnt <= off_palette_cnt + CNT_W'(is_off_palette(pixel_in));
        // Address wraps modulo the RAM size by truncation.
        wr_addr         <= base_q + pix_cnt[ADDR_W-1:0];
        wr_data         <= quantize(pixel_in, THRESH);
      end
    end
  end

endmodule

// File: tb/tb_sprite_bitmap_writer.sv
module tb_sprite_bitmap_writer;

  localparam int AW = 10;

  logic          Clk = 1'b0;
  logic          Reset_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [23:0]   pixel_in = '0;
  logic          pixel_valid = 1'b0;
  logic          pixel_ready, wr_en, wr_data, busy, done;
  logic [AW-1:0] wr_addr;
  logic [AW:0]   off_palette_cnt;

  int checks = 0;
  int failures = 0;

  sprite_bitmap_writer #(.ADDR_W(AW), .NUM_PIX(1024), .THRESH(10'd384)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .start(start), .abort(abort),
    .base_addr(base_addr), .pixel_in(pixel_in), .pixel_valid(pixel_valid),
    .pixel_ready(pixel_ready), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy), .done(done),
    .off_palette_cnt(off_palette_cnt)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // mode 0: alternating white/black; mode 1: off-palette and threshold
  // corner pixels then white; mode 2: all black.
  function automatic logic [23:0] pix_of(input int mode, input int k);
    case (mode)
      0: return (k % 2 == 0) ? 24'hFFFFFF : 24'h000000;
      1: case (k)
           0: return 24'h404040;  // sum 192 -> 1
           1: return 24'hC0C0C0;  // sum 576 -> 0
           2: return 24'h808080;  // sum 384 -> 0
           3: return 24'h7F8080;  // sum 383 -> 1
           4: return 24'hFFFFFE;  // sum 764 -> 0
           default: return 24'hFFFFFF;
         endcase
      default: return 24'h000000;
    endcase
  endfunction

  function automatic logic exp_data(input int mode, input int k);
    case (mode)
      0: return (k % 2 == 1);
      1: return (k == 0 || k == 3);
      default: return 1'b1;
    endcase
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, pixel_ready, 0);
    check({tag, "_wr_en"}, wr_en, 0);
    check({tag, "_wr_addr"}, wr_addr, 0);
    check({tag, "_wr_data"}, wr_data, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_off_cnt"}, off_palette_cnt, 0);
  endtask

  // Called at a falling edge while idle; returns at the falling edge where LOAD is visible.
  task automatic do_start(input logic [AW-1:0] base);
    start = 1'b1;
    base_addr = base;
    @(negedge Clk);
    start = 1'b0;
    check("start_busy", busy, 1);
    check("start_ready", pixel_ready, 1);
  endtask

  task automatic full_load(input logic [AW-1:0] base, input int mode, input int exp_off);
    logic [AW-1:0] ea;
    do_start(base);
    pixel_valid = 1'b1;
    pixel_in = pix_of(mode, 0);
    for (int k = 0; k < 1024; k++) begin
      @(negedge Clk);
      ea = base + AW'(k);
      check("load_wr_en", wr_en, 1);
      check("load_wr_addr", wr_addr, ea);
      check("load_wr_data", wr_data, exp_data(mode, k));
      check("load_done", done, (k == 1023));
      check("load_busy", busy, (k != 1023));
      pixel_in = pix_of(mode, k + 1);
    end
    check("done_ready_low", pixel_ready, 0);
    check("done_off_cnt", off_palette_cnt, exp_off);
    @(negedge Clk);
    check("post_no_write", wr_en, 0);
    check("post_done_low", done, 0);
    check("post_off_hold", off_palette_cnt, exp_off);
    pixel_valid = 1'b0;
    @(negedge Clk);
  endtask

  initial begin
    // Reset
    #1;
    check_all_zero("reset");
    @(negedge Clk);
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
    check_all_zero("idle");

    // Full load, alternating palette pixels
    full_load(10'd0, 0, 0);

    // Backpressure: valid 1,0,1,0 then abort
    do_start(10'd50);
    pixel_valid = 1'b1; pixel_in = 24'h000000;
    @(negedge Clk);
    check("bp_w0_en", wr_en, 1); check("bp_w0_addr", wr_addr, 50); check("bp_w0_data", wr_data, 1);
    pixel_valid = 1'b0; pixel_in = 24'hFFFFFF;
    @(negedge Clk);
    check("bp_gap0_en", wr_en, 0);
    pixel_valid = 1'b1;
    @(negedge Clk);
    check("bp_w1_en", wr_en, 1); check("bp_w1_addr", wr_addr, 51); check("bp_w1_data", wr_data, 0);
    pixel_valid = 1'b0;
    @(negedge Clk);
    check("bp_gap1_en", wr_en, 0);
    check("bp_busy", busy, 1);
    abort = 1'b1;
    @(negedge Clk);
    abort = 1'b0;
    check("bp_abort_busy", busy, 0);
    check("bp_abort_done", done, 0);

    // Off-palette and threshold corners
    full_load(10'd7, 1, 5);

    // Address wrap from base 1000
    full_load(10'd1000, 2, 0);

    // Abort after 5 accepts with pixel_valid still high
    do_start(10'd200);
    pixel_valid = 1'b1; pixel_in = 24'h404040;
    for (int k = 0; k < 5; k++) begin
      @(negedge Clk);
      check("ab_wr_en", wr_en, 1);
      check("ab_wr_addr", wr_addr, 200 + k);
      check("ab_wr_data", wr_data, 1);
    end
    check("ab_off_cnt", off_palette_cnt, 5);
    abort = 1'b1;
    @(negedge Clk);
    abort = 1'b0; pixel_valid = 1'b0;
    check("ab_no_write", wr_en, 0);
    check("ab_no_done", done, 0);
    check("ab_busy_low", busy, 0);
    check("ab_ready_low", pixel_ready, 0);
    @(negedge Clk);
    check("ab_idle_wr_en", wr_en, 0);
    check("ab_idle_done", done, 0);
    // start and abort together in IDLE: start wins
    start = 1'b1; abort = 1'b1; base_addr = 10'd0;
    @(negedge Clk);
    start = 1'b0; abort = 1'b0;
    check("ab_restart_busy", busy, 1);
    check("ab_restart_off_clr", off_palette_cnt, 0);
    pixel_valid = 1'b1; pixel_in = 24'hFFFFFF;
    @(negedge Clk);
    pixel_valid = 1'b0;
    check("ab_restart_en", wr_en, 1);
    check("ab_restart_addr", wr_addr, 0);
    check("ab_restart_data", wr_data, 0);
    abort = 1'b1;
    @(negedge Clk);
    abort = 1'b0;
    check("ab_second_abort", busy, 0);

    // Reset mid-load at write 300; start held during load is ignored
    do_start(10'd0);
    pixel_valid = 1'b1;
    pixel_in = 24'h404040;
    for (int k = 0; k <= 300; k++) begin
      @(negedge Clk);
      check("rs_wr_en", wr_en, 1);
      check("rs_wr_addr", wr_addr, k);
      check("rs_wr_data", wr_data, (k % 2 == 0));
      start = (k >= 100 && k < 110);
      base_addr = 10'd500;
      pixel_in = (k % 2 == 1) ? 24'h404040 : 24'hFFFFFF;
    end
    start = 1'b0;
    check("rs_off_before", off_palette_cnt, 151);
    check("rs_busy_before", busy, 1);
    Reset_n = 1'b0;
    #1;
    check_all_zero("rs_async");
    @(negedge Clk);
    check_all_zero("rs_hold1");
    @(negedge Clk);
    check_all_zero("rs_hold2");
    Reset_n = 1'b1;
    pixel_valid = 1'b0;
    @(negedge Clk);
    check_all_zero("rs_after");
    do_start(10'd3);
    pixel_valid = 1'b1; pixel_in = 24'h000000;
    @(negedge Clk);
    pixel_valid = 1'b0;
    check("rs_new_addr", wr_addr, 3);
    check("rs_new_data", wr_data, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5000000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
